// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_VW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; never zero even for a 1-bit dividend.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on a VW+1 bit partial remainder.
module div_step #(
  parameter int unsigned VW = 8
) (
  input  logic [VW:0]   rem,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_next,
  output logic          q_bit
);

  logic [VW:0] shifted;

  always_comb begin
    shifted  = {rem[VW-1:0], bit_in};
    // A set MSB means the true shifted value exceeds VW+1 bits, so it is surely >= divisor.
    q_bit    = rem[VW] | (shifted >= {1'b0, divisor});
    rem_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned divider: one quotient bit per cycle, valid/ready on both sides.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero
);

  localparam int unsigned CW = cnt_width(DW);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   rem_q, rem_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] div_q, div_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rmd_q, rmd_d;
  logic          dz_q, dz_d;

  logic [VW:0]   step_rem;
  logic          step_q;

  div_step #(
    .VW(VW)
  ) u_step (
    .rem      (rem_q),
    .bit_in   (dvd_q[DW-1]),
    .divisor  (div_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (b == '0) begin
            state_d = DONE;
            quo_d   = '0;
            rmd_d   = a;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = '0;
            dvd_d   = a;
            div_d   = b;
            cnt_d   = CW'(DW - 1);
            dz_d    = 1'b0;
          end
        end
      end
      RUN: begin
        // Dividend bits leave at the MSB while quotient bits enter at the LSB.
        rem_d = step_rem;
        dvd_d = {dvd_q[DW-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = {dvd_q[DW-2:0], step_q};
          rmd_d   = DW'(step_rem[VW-1:0]);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter DW, default 16: dividend, quotient and remainder width in bits.
REQ-002 Parameter VW, default 8: divisor width in bits; legal range 1 <= VW <= DW.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  DW  dividend, unsigned.
REQ-008 b  input  VW  divisor, unsigned.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  DW  floor(a/b).
REQ-012 remainder  output  DW  a mod b, zero-extended from VW bits.
REQ-013 div_zero  output  1  result came from b == 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 An operand pair SHALL be captured on the edge where in_valid && in_ready; a and b SHALL be ignored at all other edges.
REQ-017 On capture with b != 0, the FSM SHALL go to RUN, clear the partial remainder, load the dividend shift register and load the iteration counter with DW-1.
REQ-018 On capture with b == 0, the FSM SHALL go directly to DONE with quotient = 0, remainder = a and div_zero = 1.
REQ-019 Each RUN edge SHALL perform one radix-2 restoring step, MSB first.
REQ-019a Shift the partial remainder left, bringing in the next dividend bit.
REQ-019b If the shifted value >= b, subtract b and set the quotient bit to 1; otherwise set it to 0.
REQ-020 The partial remainder SHALL be VW+1 bits wide, so no step can overflow.
REQ-021 RUN SHALL last exactly DW edges; the FSM SHALL enter DONE on the edge where the counter equals 0.
REQ-021a Latency: out_valid rises DW+1 edges after the capture edge (1 edge for b == 0).
REQ-022 In DONE, quotient, remainder and div_zero SHALL hold stable while out_valid && !out_ready, for any number of cycles.
REQ-023 On the edge where out_valid && out_ready, the FSM SHALL return to IDLE.
REQ-023a quotient, remainder and div_zero SHALL keep their last values until the next capture.
REQ-024 in_valid asserted during RUN or DONE SHALL have no effect; the source must hold it until in_ready.
REQ-025 div_zero SHALL be cleared on every capture with b != 0.

Reset
REQ-026 While rst_n = 0: FSM in IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_zero = 0, counter = 0.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL abort the operation immediately, with no result ever presented.
REQ-028 The first capture SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package div_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default DW/VW constants.
REQ-030 One restoring iteration SHALL live in combinational sub-module div_step, parametrised by VW.
REQ-030a div_step inputs: partial remainder, incoming dividend bit, divisor.
REQ-030b div_step outputs: next partial remainder, quotient bit.
REQ-031 No division operator SHALL appear in synthesizable RTL.

Verification (DW=16, VW=8)
REQ-032 a=1000, b=7, out_ready=1: out_valid 17 edges after capture; quotient=142, remainder=6, div_zero=0.
REQ-033 a=65535, b=255: quotient=257, remainder=0; a=3, b=200: quotient=0, remainder=3.
REQ-034 a=5, b=0: out_valid 1 edge after capture; quotient=0, remainder=5, div_zero=1.
REQ-035 a=1000, b=7, out_ready held 0 for 5 cycles after out_valid: outputs stay 142/6, in_ready stays 0; IDLE one edge after out_ready=1.
REQ-036 rst_n pulsed low 8 edges into RUN:
REQ-036a Immediately after: out_valid=0, in_ready=1, outputs 0.
REQ-036b A new pair 100/9 then gives quotient=11, remainder=1.
REQ-037 Random sweep, 10k pairs including b in {0,1,255} and a in {0,65535}, random out_ready backpressure: all results match a scoreboard.
